// File: rtl/risc_memwb.sv
// risc_memwb: memory/writeback stage of the 8-bit RISC pipeline.
//
// Serves the execution unit's data-memory requests from a DEPTH x 8 memory and
// drives the register-file write port for ALU results and multi-cycle loads.
// While a load is outstanding, stall holds the upstream pipeline registers.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   dmenbl, rdwr, dmaddr          memory request (rdwr: 1 = read, 0 = write)
//   dmdatain                      store data
//   load_op, rslt, dst            load flag, ALU result, destination register
//   reg_wr_vld                    instruction writes the register file
//   stall                         upstream must hold its output registers
//   rf_we, rf_waddr, rf_wdata     register-file write port (rf_we is a pulse)
//   err                           sticky protocol-error flag
//   dbg_addr, dbg_data            combinational debug read of the memory
module risc_memwb #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned RD_LAT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       dmenbl,
    input  logic       rdwr,
    input  logic [3:0] dmaddr,
    input  logic [7:0] dmdatain,
    input  logic       load_op,
    input  logic [7:0] rslt,
    input  logic [2:0] dst,
    input  logic       reg_wr_vld,
    output logic       stall,
    output logic       rf_we,
    output logic [2:0] rf_waddr,
    output logic [7:0] rf_wdata,
    output logic       err,
    input  logic [3:0] dbg_addr,
    output logic [7:0] dbg_data
);

    typedef enum logic [0:0] {StIdle, StRdWait} state_e;

    state_e     state;
    logic [1:0] cnt;
    logic [3:0] addr_q;
    logic [2:0] dst_q;
    logic [7:0] mem [DEPTH];

    // Addresses at or above DEPTH alias back into the memory.
    function automatic logic [3:0] wrap(input logic [3:0] a);
        return 4'({1'b0, a} % 5'(DEPTH));
    endfunction

    logic is_err, is_store, is_load, is_alu;

    always_comb begin
        is_err   = (dmenbl & rdwr & ~load_op) | (~dmenbl & load_op);
        is_store = ~is_err & dmenbl & ~rdwr;
        is_load  = ~is_err & dmenbl & rdwr & load_op;
        is_alu   = ~is_err & ~dmenbl & reg_wr_vld;
    end

    // Taken straight from the state register so it cannot glitch.
    assign stall    = (state == StRdWait);
    assign dbg_data = mem[wrap(dbg_addr)];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= StIdle;
            cnt      <= 2'd0;
            addr_q   <= 4'd0;
            dst_q    <= 3'd0;
            rf_we    <= 1'b0;
            rf_waddr <= 3'd0;
            rf_wdata <= 8'h00;
            err      <= 1'b0;
            mem      <= '{default: 8'h00};
        end else begin
            unique case (state)
                StIdle: begin
                    rf_we <= 1'b0;
                    if (is_err) begin
                        err <= 1'b1;
                    end else if (is_store) begin
                        // Stores never write back, even with reg_wr_vld set.
                        mem[wrap(dmaddr)] <= dmdatain;
                    end else if (is_load) begin
                        addr_q <= dmaddr;
                        dst_q  <= dst;
                        cnt    <= 2'(RD_LAT - 1);
                        state  <= StRdWait;
                    end else if (is_alu) begin
                        rf_we    <= 1'b1;
                        rf_waddr <= dst;
                        rf_wdata <= rslt;
                    end
                end
                StRdWait: begin
                    // Inputs are ignored here; upstream holds the next instruction.
                    if (cnt != 2'd0) begin
                        cnt   <= cnt - 2'd1;
                        rf_we <= 1'b0;
                    end else begin
                        rf_we    <= 1'b1;
                        rf_waddr <= dst_q;
                        rf_wdata <= mem[wrap(addr_q)];
                        state    <= StIdle;
                    end
                end
                default: begin
                    state <= StIdle;
                    rf_we <= 1'b0;
                end
            endcase
        end
    end

endmodule
